// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the default protection value.
// The peripheral slave wrappers decode the same response codes.
package axi4_lite_pkg;

    // BRESP / RRESP encodings
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Unprivileged, secure, data access
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4_lite_master.sv
// AXI4-Lite master: turns a single-outstanding valid/done request port into AW/W/B or
// AR/R handshakes. One transaction in flight; every output comes straight from a flop.
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      iCLK,
    input  logic                      iRST,

    // Request port
    input  logic                      req_VALID,
    input  logic                      req_WRITE,
    input  logic [ADDR_WIDTH-1:0]     req_ADDR,
    input  logic [DATA_WIDTH-1:0]     req_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   req_WSTRB,
    output logic                      req_DONE,
    output logic [DATA_WIDTH-1:0]     req_RDATA,
    output logic [1:0]                req_RESP,
    output logic                      req_BUSY,

    // Write address channel
    output logic                      m_AWVALID,
    input  logic                      m_AWREADY,
    output logic [ADDR_WIDTH-1:0]     m_AWADDR,
    output logic [2:0]                m_AWPROT,

    // Write data channel
    output logic                      m_WVALID,
    input  logic                      m_WREADY,
    output logic [DATA_WIDTH-1:0]     m_WDATA,
    output logic [DATA_WIDTH/8-1:0]   m_WSTRB,

    // Write response channel
    input  logic                      m_BVALID,
    output logic                      m_BREADY,
    input  logic [1:0]                m_BRESP,

    // Read address channel
    output logic                      m_ARVALID,
    input  logic                      m_ARREADY,
    output logic [ADDR_WIDTH-1:0]     m_ARADDR,
    output logic [2:0]                m_ARPROT,

    // Read data channel
    input  logic                      m_RVALID,
    output logic                      m_RREADY,
    input  logic [DATA_WIDTH-1:0]     m_RDATA,
    input  logic [1:0]                m_RRESP
);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StWresp,
        StRaddr,
        StRdata,
        StDone
    } state_e;

    state_e                    state_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH/8-1:0]   wstrb_q;

    // AW and W are allowed to finish independently; a channel counts as finished once its
    // VALID has already dropped or its handshake happens on this edge.
    logic aw_fin;
    logic w_fin;

    // Completion status of the two write-request channels for the current cycle
    always_comb begin
        aw_fin = ~m_AWVALID | m_AWREADY;
        w_fin  = ~m_WVALID  | m_WREADY;
    end

    // Request capture, handshake sequencing and registered outputs
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            m_AWVALID <= 1'b0;
            m_WVALID  <= 1'b0;
            m_BREADY  <= 1'b0;
            m_ARVALID <= 1'b0;
            m_RREADY  <= 1'b0;
            req_DONE  <= 1'b0;
            req_BUSY  <= 1'b0;
            req_RDATA <= '0;
            req_RESP  <= RESP_OKAY;
        end else begin
            req_DONE <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_VALID) begin
                        addr_q   <= req_ADDR;
                        wdata_q  <= req_WDATA;
                        wstrb_q  <= req_WSTRB;
                        req_BUSY <= 1'b1;
                        if (req_WRITE) begin
                            m_AWVALID <= 1'b1;
                            m_WVALID  <= 1'b1;
                            state_q   <= StWrite;
                        end else begin
                            m_ARVALID <= 1'b1;
                            state_q   <= StRaddr;
                        end
                    end
                end

                StWrite: begin
                    if (m_AWREADY) begin
                        m_AWVALID <= 1'b0;
                    end
                    if (m_WREADY) begin
                        m_WVALID <= 1'b0;
                    end
                    if (aw_fin && w_fin) begin
                        m_BREADY <= 1'b1;
                        state_q  <= StWresp;
                    end
                end

                StWresp: begin
                    if (m_BVALID && m_BREADY) begin
                        req_RESP <= m_BRESP;
                        m_BREADY <= 1'b0;
                        req_DONE <= 1'b1;
                        state_q  <= StDone;
                    end
                end

                StRaddr: begin
                    if (m_ARVALID && m_ARREADY) begin
                        m_ARVALID <= 1'b0;
                        m_RREADY  <= 1'b1;
                        state_q   <= StRdata;
                    end
                end

                StRdata: begin
                    if (m_RVALID && m_RREADY) begin
                        req_RDATA <= m_RDATA;
                        req_RESP  <= m_RRESP;
                        m_RREADY  <= 1'b0;
                        req_DONE  <= 1'b1;
                        state_q   <= StDone;
                    end
                end

                StDone: begin
                    // req_DONE is high during this cycle; BUSY covers it inclusively
                    req_BUSY <= 1'b0;
                    state_q  <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Payload is held in the capture registers, so it stays stable while VALID waits
    always_comb begin
        m_AWADDR = addr_q;
        m_ARADDR = addr_q;
        m_WDATA  = wdata_q;
        m_WSTRB  = wstrb_q;
        m_AWPROT = PROT_DEFAULT;
        m_ARPROT = PROT_DEFAULT;
    end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Self-checking bench for axi4_lite_master: table of directed transactions, hand-written
// reset / stray-response sequences, then randomized transactions against a timing model.
module tb_axi4_lite_master;
    import axi4_lite_pkg::*;

    logic        iCLK;
    logic        iRST;
    logic        req_VALID, req_WRITE;
    logic [31:0] req_ADDR, req_WDATA;
    logic [3:0]  req_WSTRB;
    logic        req_DONE, req_BUSY;
    logic [31:0] req_RDATA;
    logic [1:0]  req_RESP;
    logic        m_AWVALID, m_AWREADY;
    logic [31:0] m_AWADDR;
    logic [2:0]  m_AWPROT;
    logic        m_WVALID, m_WREADY;
    logic [31:0] m_WDATA;
    logic [3:0]  m_WSTRB;
    logic        m_BVALID, m_BREADY;
    logic [1:0]  m_BRESP;
    logic        m_ARVALID, m_ARREADY;
    logic [31:0] m_ARADDR;
    logic [2:0]  m_ARPROT;
    logic        m_RVALID, m_RREADY;
    logic [31:0] m_RDATA;
    logic [1:0]  m_RRESP;

    int checks = 0;
    int errors = 0;

    axi4_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .req_VALID(req_VALID), .req_WRITE(req_WRITE), .req_ADDR(req_ADDR),
        .req_WDATA(req_WDATA), .req_WSTRB(req_WSTRB), .req_DONE(req_DONE),
        .req_RDATA(req_RDATA), .req_RESP(req_RESP), .req_BUSY(req_BUSY),
        .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY), .m_AWADDR(m_AWADDR),
        .m_AWPROT(m_AWPROT),
        .m_WVALID(m_WVALID), .m_WREADY(m_WREADY), .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB),
        .m_BVALID(m_BVALID), .m_BREADY(m_BREADY), .m_BRESP(m_BRESP),
        .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY), .m_ARADDR(m_ARADDR),
        .m_ARPROT(m_ARPROT),
        .m_RVALID(m_RVALID), .m_RREADY(m_RREADY), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // d_a: AW/AR wait cycles, d_w: W wait cycles, d_r: B/R wait cycles after request phase
    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          d_a;
        int          d_w;
        int          d_r;
        logic [1:0]  resp;
        bit          stray;
        bit          hold;
    } txn_t;

    typedef struct {
        txn_t        t;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk_txn(input bit write, input logic [31:0] addr,
                                    input logic [31:0] data, input logic [3:0] strb,
                                    input int d_a, input int d_w, input int d_r,
                                    input logic [1:0] resp, input bit stray, input bit hold);
        txn_t t;
        t.write = write; t.addr = addr; t.data = data; t.strb = strb;
        t.d_a = d_a; t.d_w = d_w; t.d_r = d_r; t.resp = resp;
        t.stray = stray; t.hold = hold;
        return t;
    endfunction

    // Cycles from the acceptance cycle through the DONE cycle, inclusive
    function automatic int model_lat(input txn_t t);
        if (t.write) return 4 + ((t.d_a > t.d_w) ? t.d_a : t.d_w) + t.d_r;
        return 4 + t.d_a + t.d_r;
    endfunction

    task automatic clear_slave();
        m_AWREADY = 0; m_WREADY = 0; m_BVALID = 0; m_BRESP = 0;
        m_ARREADY = 0; m_RVALID = 0; m_RDATA = 0; m_RRESP = 0;
    endtask

    // Issue one request and act as the slave; entered and left on a negedge.
    task automatic run_txn(input txn_t t, input int exp_lat, input logic [31:0] exp_rdata,
                           input logic [1:0] exp_resp);
        int  cyc;
        int  n_aw, n_w, n_b, n_ar, n_r;
        int  a_cnt, w_cnt, r_cnt;
        bit  done, real_v;
        cyc = req_DONE ? -1 : 0;
        if (!req_DONE) check("idle_busy", req_BUSY, 0);
        req_VALID = 1; req_WRITE = t.write; req_ADDR = t.addr;
        req_WDATA = t.write ? t.data : $urandom; req_WSTRB = t.strb;
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
        a_cnt = 0; w_cnt = 0; r_cnt = 0; done = 0;
        clear_slave();
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge iCLK);
            cyc++;
            if (cyc == 1 && !t.hold) begin
                req_VALID = 0; req_WRITE = ~t.write; req_ADDR = $urandom;
                req_WDATA = $urandom; req_WSTRB = $urandom;
            end
            if (cyc == 0) begin
                check("done_single", req_DONE, 0);
                check("idle_busy", req_BUSY, 0);
            end
            // Expected channel activity from handshakes seen so far
            check("awvalid", m_AWVALID, cyc >= 1 && t.write && n_aw == 0);
            check("wvalid", m_WVALID, cyc >= 1 && t.write && n_w == 0);
            check("bready", m_BREADY, t.write && n_aw == 1 && n_w == 1 && n_b == 0);
            check("arvalid", m_ARVALID, cyc >= 1 && !t.write && n_ar == 0);
            check("rready", m_RREADY, !t.write && n_ar == 1 && n_r == 0);
            if (m_AWVALID) check("awaddr", {m_AWPROT, m_AWADDR}, {3'b000, t.addr});
            if (m_WVALID) check("wpayload", {m_WSTRB, m_WDATA}, {t.strb, t.data});
            if (m_ARVALID) check("araddr", {m_ARPROT, m_ARADDR}, {3'b000, t.addr});
            if (cyc >= 1 && req_DONE) begin
                done = 1;
                check("latency", cyc + 1, exp_lat);
                check("resp", req_RESP, exp_resp);
                if (!t.write) check("rdata", req_RDATA, exp_rdata);
                check("done_busy", req_BUSY, 1);
                check("hs_aw_w_b", {n_aw[7:0], n_w[7:0], n_b[7:0]},
                      t.write ? 24'h010101 : 24'h0);
                check("hs_ar_r", {n_ar[7:0], n_r[7:0]}, t.write ? 16'h0 : 16'h0101);
                clear_slave();
            end else begin
                if (cyc >= 1) check("busy", req_BUSY, 1);
                // Response channels
                real_v = 0;
                if (t.write && n_aw == 1 && n_w == 1 && n_b == 0) begin
                    if (r_cnt >= t.d_r) real_v = 1; else r_cnt++;
                    m_BVALID = real_v;
                end else begin
                    m_BVALID = t.stray && !t.write;
                end
                m_BRESP = real_v ? t.resp : ~t.resp;
                real_v = 0;
                if (!t.write && n_ar == 1 && n_r == 0) begin
                    if (r_cnt >= t.d_r) real_v = 1; else r_cnt++;
                    m_RVALID = real_v;
                end else begin
                    m_RVALID = t.stray && t.write;
                end
                m_RDATA = real_v ? t.data : ~t.data;
                m_RRESP = real_v ? t.resp : ~t.resp;
                // Request channels
                m_AWREADY = m_AWVALID && (a_cnt >= t.d_a);
                if (m_AWVALID && !m_AWREADY) a_cnt++;
                m_WREADY = m_WVALID && (w_cnt >= t.d_w);
                if (m_WVALID && !m_WREADY) w_cnt++;
                m_ARREADY = m_ARVALID && (a_cnt >= t.d_a);
                if (m_ARVALID && !m_ARREADY) a_cnt++;
                // Handshakes completing on the coming edge
                n_aw += int'(m_AWVALID && m_AWREADY);
                n_w  += int'(m_WVALID && m_WREADY);
                n_b  += int'(m_BVALID && m_BREADY);
                n_ar += int'(m_ARVALID && m_ARREADY);
                n_r  += int'(m_RVALID && m_RREADY);
            end
        end
        check("txn_completed", done, 1);
        if (!t.hold) begin
            req_VALID = 0;
            @(negedge iCLK);
            check("done_single", req_DONE, 0);
            check("busy_after", req_BUSY, 0);
            check("resp_held", req_RESP, exp_resp);
            if (!t.write) check("rdata_held", req_RDATA, exp_rdata);
        end
    endtask

    vec_t vecs[6];
    txn_t rt;

    initial begin
        iRST = 1;
        req_VALID = 0; req_WRITE = 0; req_ADDR = 0; req_WDATA = 0; req_WSTRB = 0;
        clear_slave();

        vecs[0] = '{t: mk_txn(1, 32'h0000_0004, 32'hA5A5_1234, 4'hF, 0, 0, 0, RESP_OKAY, 0, 0),
                    exp_rdata: 32'h0, exp_resp: 2'b00, exp_lat: 4};
        vecs[1] = '{t: mk_txn(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'h3, 0, 3, 1, RESP_OKAY, 0, 0),
                    exp_rdata: 32'h0, exp_resp: 2'b00, exp_lat: 8};
        vecs[2] = '{t: mk_txn(0, 32'h0000_0008, 32'h0000_FFFF, 4'h0, 0, 0, 5, RESP_SLVERR, 1, 0),
                    exp_rdata: 32'h0000_FFFF, exp_resp: 2'b10, exp_lat: 9};
        vecs[3] = '{t: mk_txn(1, 32'h0000_0020, 32'h1234_5678, 4'h0, 0, 0, 0, RESP_DECERR, 0, 1),
                    exp_rdata: 32'h0, exp_resp: 2'b11, exp_lat: 4};
        vecs[4] = '{t: mk_txn(0, 32'h0000_0024, 32'hCAFE_F00D, 4'h0, 0, 0, 0, RESP_EXOKAY, 0, 0),
                    exp_rdata: 32'hCAFE_F00D, exp_resp: 2'b01, exp_lat: 4};
        vecs[5] = '{t: mk_txn(1, 32'h0000_0030, 32'h0BAD_F00D, 4'hC, 3, 0, 0, RESP_OKAY, 1, 0),
                    exp_rdata: 32'h0, exp_resp: 2'b00, exp_lat: 7};

        // Reset values
        #12;
        check("rst_ctrl", {m_AWVALID, m_WVALID, m_BREADY, m_ARVALID, m_RREADY, req_DONE, req_BUSY},
              7'b0);
        check("rst_rdata_resp", {req_RDATA, req_RESP}, 34'h0);
        check("rst_payload", {m_AWADDR, m_ARADDR, m_WDATA, m_WSTRB}, 100'h0);
        check("rst_prot", {m_AWPROT, m_ARPROT}, 6'h0);
        @(negedge iCLK);
        iRST = 0;
        @(negedge iCLK);

        // Stray responses while idle must not start or complete anything
        m_BVALID = 1; m_RVALID = 1; m_BRESP = RESP_SLVERR; m_RRESP = RESP_SLVERR;
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            check("stray_idle", {req_DONE, req_BUSY, m_BREADY, m_RREADY}, 4'b0);
        end
        clear_slave();

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].t, vecs[i].exp_lat, vecs[i].exp_rdata, vecs[i].exp_resp);
        end

        // Reset while W is still pending
        req_VALID = 1; req_WRITE = 1; req_ADDR = 32'h40; req_WDATA = 32'h5555_AAAA;
        req_WSTRB = 4'hF; m_AWREADY = 1; m_WREADY = 0;
        @(negedge iCLK);
        req_VALID = 0;
        @(negedge iCLK);
        check("mid_wvalid_pending", {m_AWVALID, m_WVALID}, 2'b01);
        #2 iRST = 1;
        #1;
        check("rst_async_ctrl",
              {m_AWVALID, m_WVALID, m_BREADY, m_ARVALID, m_RREADY, req_DONE, req_BUSY}, 7'b0);
        check("rst_async_payload", {m_WDATA, req_RESP}, 34'h0);
        @(negedge iCLK);
        iRST = 0;
        m_WREADY = 1; m_BVALID = 1; m_BRESP = RESP_OKAY;
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            check("no_done_after_rst", {req_DONE, req_BUSY, m_WVALID}, 3'b0);
        end
        clear_slave();
        rt = mk_txn(0, 32'h44, 32'h1357_9BDF, 4'h0, 0, 0, 0, RESP_OKAY, 0, 0);
        run_txn(rt, 4, 32'h1357_9BDF, RESP_OKAY);

        // Randomized transactions against the timing/response model
        for (int i = 0; i < 40; i++) begin
            rt.write = 1'($urandom);
            rt.addr  = $urandom & 32'hFFFF_FFFC;
            rt.data  = $urandom;
            rt.strb  = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
            rt.d_a   = $urandom_range(0, 4);
            rt.d_w   = $urandom_range(0, 4);
            rt.d_r   = $urandom_range(0, 4);
            rt.resp  = 2'($urandom);
            rt.stray = ($urandom_range(0, 3) == 0);
            rt.hold  = (i < 39) && ($urandom_range(0, 2) == 0);
            run_txn(rt, model_lat(rt), rt.data, rt.resp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
